tmds_pll_reset_seq: RTL
=======================

# tmds_pll_reset_seq

Reset and lock sequencer for the TMDS clock PLL (27 MHz in, 371.25 MHz serial clock out). It sits directly downstream of the PLL. It drives the PLL `RESET` pin and watches the asynchronous `lock` output. Once lock has been stable long enough, it releases the serializer-domain reset and then the pixel-domain reset, in that order. It also detects loss of lock and re-sequences.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop depth of the lock synchronizer (≥2).
- `PLL_RST_CYCLES`, 27: cycles `pll_reset` is held high per PLL reset pulse.
- `LOCK_STABLE_CYCLES`, 2700: consecutive synchronized-high lock cycles required (100 µs).
- `LOCK_TIMEOUT_CYCLES`, 270000: maximum dwell in WAIT_LOCK before the PLL is re-reset (10 ms).
- `RST_HOLD_CYCLES`, 16: gap between the `ser_rst` release and the `pix_rst` release.

Ports:
- `clkin` in 1: free-running 27 MHz reference, the same net that feeds the PLL. One clock.
- `rst` in 1: synchronous, active-high.
- `lock` in 1: PLL lock, asynchronous to `clkin`.
- `pll_reset` out 1: to PLL `RESET`, active-high.
- `ser_rst` out 1: serializer/TMDS-domain reset, active-high. The consumer re-synchronizes it.
- `pix_rst` out 1: pixel-domain reset, active-high.
- `ready` out 1: high only in RUN.
- `relock_count` out 8: loss-of-lock events seen in RUN; saturates at 255.
- `state` out 3: current FSM state, for debug.

## Operation
- `lock` passes through a `SYNC_STAGES` synchronizer to form `lock_s`. All decisions use `lock_s`.
- States and encodings:
  - PLL_RST=0: `pll_reset`=1, `ser_rst`=1, `pix_rst`=1. Stays `PLL_RST_CYCLES` cycles, then goes to WAIT_LOCK.
  - WAIT_LOCK=1: `pll_reset`=0, both resets=1.
    - Stable counter increments while `lock_s`=1 and clears to 0 when `lock_s`=0.
    - When stable counter = `LOCK_STABLE_CYCLES`-1 and `lock_s`=1, go to REL_SER.
    - Timeout counter increments every cycle in this state. At `LOCK_TIMEOUT_CYCLES`-1 without success, go to PLL_RST.
    - If success and timeout occur in the same cycle, success wins.
  - REL_SER=2: `ser_rst`=0, `pix_rst`=1. Stays `RST_HOLD_CYCLES` cycles, then goes to RUN via REL_PIX.
  - REL_PIX=3: single cycle, `pix_rst` deasserts. Next state is RUN.
  - RUN=4: all resets=0, `ready`=1.
- Loss of lock:
  - `lock_s`=0 in REL_SER, REL_PIX or RUN: next state is WAIT_LOCK and both resets reassert on that clock edge.
  - `relock_count` increments only on exits from RUN. Exits from REL_SER/REL_PIX do not count.
  - Loss of lock goes to WAIT_LOCK, not PLL_RST. A PLL reset happens only on timeout.
- `rst`=1 in any state: next cycle is PLL_RST with counters cleared and `relock_count`=0. This applies mid-sequence too.
- Counter width is `$clog2` of the largest of the cycle parameters. The stable, hold and PLL-reset phases share one counter, cleared on every state entry. The timeout counter is separate.

## Timing
- All outputs are registered.
- Reset values: `pll_reset`=1, `ser_rst`=1, `pix_rst`=1, `ready`=0, `relock_count`=0, `state`=0.
- `lock` to `lock_s` latency is `SYNC_STAGES` cycles. `lock_s` falling to resets asserted is 1 further cycle.
- Clean bring-up, from first cycle without `rst` to `ready`=1, with `lock` high from the start of WAIT_LOCK: `PLL_RST_CYCLES` + `SYNC_STAGES` + `LOCK_STABLE_CYCLES` + `RST_HOLD_CYCLES` + 1 cycles.
- `ser_rst` deasserts exactly `RST_HOLD_CYCLES`+1 cycles before `pix_rst`. `pix_rst` and `ready` change on the same edge.
- A lock glitch of 1 cycle or more, once synchronized, restarts the full stable count.

## Structure
- Package `tmds_clk_pkg`: state enum `seq_state_t` with the encodings above, and the default cycle constants.
- Sub-module `sync_bit`: parameterized N-flop synchronizer, no reset on the data path. It is reused for `lock`.

## Test plan
Bench parameters: `SYNC`=2, `PLL_RST`=3, `STABLE`=8, `TIMEOUT`=64, `HOLD`=4.
- Bring-up, `lock` held at 1:
  - `pll_reset` high for 3 cycles.
  - `ser_rst` falls 10 cycles after WAIT_LOCK entry.
  - `pix_rst`/`ready` change 5 cycles later.
  - Total 18 cycles.
- `lock` never rises: `pll_reset` re-pulses for 3 cycles every 67 cycles; `ready` stays 0.
- `lock` high 6 cycles, low 1 cycle, high again: stable count restarts; REL_SER is entered 8 cycles after the second rise plus 2 sync cycles.
- In RUN, drop `lock` for 5 cycles:
  - Both resets reassert 3 cycles after the fall and `relock_count`=1.
  - Recovery without `pll_reset`.
  - 256 repeats keep `relock_count`=255.
- Drop `lock` during REL_SER: WAIT_LOCK is re-entered and `relock_count` is unchanged.
- Assert `rst` for 1 cycle during REL_SER: next cycle `state`=0 with all outputs at their reset values.

Source files
------------

// File: rtl/tmds_clk_pkg.sv
// Shared types and default timing constants for the TMDS PLL reset/lock sequencer.
package tmds_clk_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        REL_SER   = 3'd2,
        REL_PIX   = 3'd3,
        RUN       = 3'd4
    } seq_state_t;

    // Defaults for a 27 MHz reference clock
    localparam int unsigned DEF_SYNC_STAGES         = 2;
    localparam int unsigned DEF_PLL_RST_CYCLES      = 27;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 2700;    // 100 us
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 270000;  // 10 ms
    localparam int unsigned DEF_RST_HOLD_CYCLES     = 16;

    typedef struct packed {
        logic pll_reset;
        logic ser_rst;
        logic pix_rst;
        logic ready;
    } seq_out_t;

    // Output levels held for the whole time the sequencer sits in a state
    function automatic seq_out_t drive_for(input seq_state_t s);
        seq_out_t o;
        o = '{pll_reset: 1'b0, ser_rst: 1'b1, pix_rst: 1'b1, ready: 1'b0};
        case (s)
            PLL_RST:   o.pll_reset = 1'b1;
            WAIT_LOCK: o.pll_reset = 1'b0;
            REL_SER:   o.ser_rst   = 1'b0;
            REL_PIX:   o.ser_rst   = 1'b0;
            RUN:       o = '{pll_reset: 1'b0, ser_rst: 1'b0, pix_rst: 1'b0, ready: 1'b1};
            default:   o.pll_reset = 1'b1;
        endcase
        return o;
    endfunction

    function automatic int unsigned max_of4(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// N-flop single-bit synchronizer; the data path carries no reset.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk) begin
        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/tmds_pll_reset_seq.sv
// Reset and lock sequencer for the TMDS serial-clock PLL: pulses the PLL reset,
// waits for a stable lock, then releases the serializer and pixel resets in order.
module tmds_pll_reset_seq
    import tmds_clk_pkg::*;
#(
    parameter int unsigned SYNC_STAGES         = DEF_SYNC_STAGES,
    parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       lock,
    output logic       pll_reset,
    output logic       ser_rst,
    output logic       pix_rst,
    output logic       ready,
    output logic [7:0] relock_count,
    output logic [2:0] state
);

    localparam int unsigned MAX_RAW = max_of4(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                              LOCK_TIMEOUT_CYCLES, RST_HOLD_CYCLES);
    localparam int unsigned MAX_CYC = (MAX_RAW < 2) ? 2 : MAX_RAW;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);

    seq_state_t       cur_state;
    seq_out_t         outs;
    logic [CNT_W-1:0] cnt;      // PLL-reset, stable and hold phases; cleared on state entry
    logic [CNT_W-1:0] tcnt;     // WAIT_LOCK dwell
    logic             lock_gated;
    logic             lock_s;

    // The PLL's lock output is meaningless while its RESET is held, so it is
    // masked ahead of the synchronizer; the stable count then always starts
    // from a freshly seen rising lock after each PLL reset pulse.
    assign lock_gated = lock & ~outs.pll_reset;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clkin),
        .d   (lock_gated),
        .q   (lock_s)
    );

    // Sequencer FSM: state, phase counters and registered outputs
    always_ff @(posedge clkin) begin
        if (rst) begin
            cur_state    <= PLL_RST;
            outs         <= drive_for(PLL_RST);
            cnt          <= '0;
            tcnt         <= '0;
            relock_count <= '0;
        end else begin
            tcnt <= '0;
            case (cur_state)
                PLL_RST: begin
                    if (cnt == PLL_LAST) begin
                        cur_state <= WAIT_LOCK;
                        outs      <= drive_for(WAIT_LOCK);
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    // Success is tested first so it wins over a coincident timeout
                    if (lock_s && (cnt == STABLE_LAST)) begin
                        cur_state <= REL_SER;
                        outs      <= drive_for(REL_SER);
                        cnt       <= '0;
                    end else if (tcnt == TIMEOUT_LAST) begin
                        cur_state <= PLL_RST;
                        outs      <= drive_for(PLL_RST);
                        cnt       <= '0;
                    end else begin
                        cnt  <= lock_s ? (cnt + CNT_W'(1)) : '0;
                        tcnt <= tcnt + CNT_W'(1);
                    end
                end
                REL_SER: begin
                    if (!lock_s) begin
                        cur_state <= WAIT_LOCK;
                        outs      <= drive_for(WAIT_LOCK);
                        cnt       <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        cur_state <= REL_PIX;
                        outs      <= drive_for(REL_PIX);
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                REL_PIX: begin
                    cnt <= '0;
                    if (!lock_s) begin
                        cur_state <= WAIT_LOCK;
                        outs      <= drive_for(WAIT_LOCK);
                    end else begin
                        cur_state <= RUN;
                        outs      <= drive_for(RUN);
                    end
                end
                RUN: begin
                    cnt <= '0;
                    if (!lock_s) begin
                        cur_state <= WAIT_LOCK;
                        outs      <= drive_for(WAIT_LOCK);
                        if (relock_count != 8'hFF) begin
                            relock_count <= relock_count + 8'd1;
                        end
                    end
                end
                default: begin
                    cur_state <= PLL_RST;
                    outs      <= drive_for(PLL_RST);
                    cnt       <= '0;
                end
            endcase
        end
    end

    assign pll_reset = outs.pll_reset;
    assign ser_rst   = outs.ser_rst;
    assign pix_rst   = outs.pix_rst;
    assign ready     = outs.ready;
    assign state     = cur_state;

endmodule
